branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised successor to the single-condition branch judge in the hazard-handling pipeline.
- Resolves conditional branches in EX for four condition types (BEQ/BNE/BLT/BGE).
- Predicts direction in ID with a direct-mapped table of 2-bit saturating counters, indexed by PC.
- Flags mispredictions and supplies the redirect PC; keeps branch and mispredict statistics counters.

Parameters:
- PC_W, 32, PC and target width in bits.
- BHT_ENTRIES, 16, number of counters; power of two, minimum 2.
- IDX_LSB, 2, lowest PC bit used for the index. Index = PC[IDX_LSB +: log2(BHT_ENTRIES)].
- STAT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- Id_PC  in  PC_W  PC of the instruction in ID (lookup address).
- Pred_Taken  out  1  predicted direction for Id_PC. Combinational read: 1 when counter[1] is 1.
- Ex_Valid  in  1  EX stage holds a live instruction (not a bubble or flushed slot).
- Ex_Branch  in  1  the EX instruction is a conditional branch.
- Ex_Cond  in  2  condition: 00 BEQ, 01 BNE, 10 BLT, 11 BGE.
- Ex_Is_Zero  in  1  ALU (rs−rt) result is zero.
- Ex_Is_Neg  in  1  ALU (rs−rt) signed-less-than flag, overflow-corrected.
- Ex_PC  in  PC_W  PC of the EX branch; used for the table update index.
- Ex_Pred_Taken  in  1  prediction made for this instruction in ID, carried down the pipe.
- Ex_Target  in  PC_W  computed branch target.
- Ex_PC_Plus4  in  PC_W  fall-through address.
- PCSrc  out  1  actual outcome; 0 unless Ex_Valid & Ex_Branch.
- Mispredict  out  1  combinational; drives IF/ID flush and PC redirect.
- Redirect_PC  out  PC_W  Ex_Target if PCSrc, else Ex_PC_Plus4.
- Branch_Count  out  STAT_W  resolved branches since reset.
- Miss_Count  out  STAT_W  mispredictions since reset.

Behaviour:
- Outcome rule:
  - BEQ: taken = Is_Zero.
  - BNE: taken = ~Is_Zero.
  - BLT: taken = Is_Neg.
  - BGE: taken = ~Is_Neg.
  - PCSrc is gated by resolve = Ex_Valid & Ex_Branch.
- Mispredict = resolve & (PCSrc != Ex_Pred_Taken). It is 0 for non-branches, whatever the value of Ex_Pred_Taken.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - On a clock edge with resolve: taken increments the counter, saturating at 11.
  - Not-taken decrements it, saturating at 00.
  - Only the entry indexed by Ex_PC is written.
- Latency: an update is visible to Pred_Taken from the cycle after the edge.
- Same-cycle read/write to the same index returns the old (pre-update) value. There is no bypass.
- Reset (synchronous, active-high): all entries go to 01 (weak-NT), and Branch_Count and Miss_Count go to 0.
  - Combinational outputs follow their inputs during reset.
  - rst overrides a simultaneous resolve: no table or counter update in that cycle.
- Statistics:
  - Branch_Count increments on resolve.
  - Miss_Count increments on Mispredict.
  - Both saturate at all-ones and do not wrap.
- Aliasing: PCs sharing an index share a counter. This is intended; there are no tags.
- Reset in mid-run: the whole table reinitialises in one cycle, with no multi-cycle clear state.

Decomposition:
- Shared package holds:
  - condition codes COND_BEQ/BNE/BLT/BGE.
  - counter state constants SNT/WNT/WT/ST.
  - localparam IDX_W = $clog2(BHT_ENTRIES).
- One natural sub-module, sat_counter2: a 2-bit saturating counter with inc/en inputs, replicated BHT_ENTRIES times via generate. The top holds the outcome logic, index decode and statistics.

Test Plan:
- Reset, then Id_PC=0x40 → Pred_Taken=0. Branch_Count=0, Miss_Count=0.
- BEQ at Ex_PC=0x40, Is_Zero=1, Ex_Pred_Taken=0 → PCSrc=1, Mispredict=1, Redirect_PC=Ex_Target=0x80. Next cycle Pred_Taken(0x40)=1 (entry 10), Miss_Count=1.
- Four consecutive taken resolves at 0x40 → entry saturates at 11. One not-taken resolve then leaves Pred_Taken=1 (entry 10).
- Cond 00/01/10/11 with (Is_Zero, Is_Neg) = (0,1) → PCSrc = 0, 1, 1, 0. With Ex_Valid=0 → PCSrc=0, Mispredict=0, no count change.
- Aliasing with BHT_ENTRIES=16: update 0x40 taken → lookup 0x80 (same index) reads the same counter. Same-cycle lookup of 0x40 during its update returns the old value.
- rst asserted together with a mispredicting resolve → no update. Next cycle all entries read 01 and counters read 0. Force 2^STAT_W+3 mispredicts → Miss_Count holds 0xFFFF.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predict unit.
// Holds branch condition codes, 2-bit counter state encodings and the default table
// geometry. No ports.
package branch_predict_unit_pkg;

  // Branch condition codes carried on Ex_Cond.
  localparam logic [1:0] COND_BEQ = 2'b00;
  localparam logic [1:0] COND_BNE = 2'b01;
  localparam logic [1:0] COND_BLT = 2'b10;
  localparam logic [1:0] COND_BGE = 2'b11;

  // 2-bit saturating counter states. The MSB is the predicted direction.
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Default table geometry. The top derives its own index width from its parameter.
  localparam int unsigned DEF_BHT_ENTRIES = 16;
  localparam int unsigned IDX_W           = $clog2(DEF_BHT_ENTRIES);

endpackage

// File: rtl/sat_counter2.sv
// One 2-bit saturating direction counter.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset, loads weak-not-taken
//   en    - update this counter on the next edge
//   inc   - 1: count toward strong-taken, 0: count toward strong-not-taken
//   state - current counter value
module sat_counter2
  import branch_predict_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       inc,
  output logic [1:0] state
);

  logic [1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (inc) begin
      if (state_q != ST) state_d = state_q + 2'd1;
    end else begin
      if (state_q != SNT) state_d = state_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WNT;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor and resolver.
// Predicts direction in ID from a direct-mapped table of 2-bit counters indexed by PC,
// resolves BEQ/BNE/BLT/BGE in EX, flags mispredictions with a redirect PC and keeps
// saturating statistics.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   Id_PC / Pred_Taken       - lookup address and combinational prediction
//   Ex_Valid, Ex_Branch      - live conditional branch in EX
//   Ex_Cond                  - condition code (BEQ/BNE/BLT/BGE)
//   Ex_Is_Zero, Ex_Is_Neg    - ALU flags for rs-rt
//   Ex_PC                    - branch PC, selects the table entry to train
//   Ex_Pred_Taken            - prediction made for this branch in ID
//   Ex_Target, Ex_PC_Plus4   - taken and fall-through addresses
//   PCSrc, Mispredict        - resolved outcome and mispredict flag
//   Redirect_PC              - correct next PC for the EX branch
//   Branch_Count, Miss_Count - saturating statistics since reset
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned BHT_ENTRIES = 16,
  parameter int unsigned IDX_LSB     = 2,
  parameter int unsigned STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   Id_PC,
  output logic              Pred_Taken,
  input  logic              Ex_Valid,
  input  logic              Ex_Branch,
  input  logic [1:0]        Ex_Cond,
  input  logic              Ex_Is_Zero,
  input  logic              Ex_Is_Neg,
  input  logic [PC_W-1:0]   Ex_PC,
  input  logic              Ex_Pred_Taken,
  input  logic [PC_W-1:0]   Ex_Target,
  input  logic [PC_W-1:0]   Ex_PC_Plus4,
  output logic              PCSrc,
  output logic              Mispredict,
  output logic [PC_W-1:0]   Redirect_PC,
  output logic [STAT_W-1:0] Branch_Count,
  output logic [STAT_W-1:0] Miss_Count
);

  localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

  logic            resolve;
  logic            cond_true;
  logic [IdxW-1:0] rd_idx, wr_idx;
  logic [1:0]      bht [BHT_ENTRIES];

  // Only the index field of each PC matters; the rest is folded here to mark it unused.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{Id_PC, Ex_PC};

  assign resolve = Ex_Valid & Ex_Branch;

  always_comb begin
    cond_true = 1'b0;
    unique case (Ex_Cond)
      COND_BEQ: cond_true = Ex_Is_Zero;
      COND_BNE: cond_true = ~Ex_Is_Zero;
      COND_BLT: cond_true = Ex_Is_Neg;
      COND_BGE: cond_true = ~Ex_Is_Neg;
      default:  cond_true = 1'b0;
    endcase
  end

  assign PCSrc       = resolve & cond_true;
  assign Mispredict  = resolve & (PCSrc != Ex_Pred_Taken);
  assign Redirect_PC = PCSrc ? Ex_Target : Ex_PC_Plus4;

  assign rd_idx = Id_PC[IDX_LSB +: IdxW];
  assign wr_idx = Ex_PC[IDX_LSB +: IdxW];

  // Registered table, so a same-cycle lookup of the entry being trained sees the old value.
  for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
    sat_counter2 u_ctr (
      .clk   (clk),
      .rst   (rst),
      .en    (resolve && (wr_idx == IdxW'(i))),
      .inc   (PCSrc),
      .state (bht[i])
    );
  end

  assign Pred_Taken = bht[rd_idx][1];

  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (resolve && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + STAT_W'(1);
    if (Mispredict && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign Branch_Count = branch_cnt_q;
  assign Miss_Count   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios with literal
// expectations, a randomized phase and a statistics saturation run, all checked every
// cycle against a behavioural table model.
module tb_branch_predict_unit;

  localparam int unsigned PC_W        = 32;
  localparam int unsigned BHT_ENTRIES = 16;
  localparam int unsigned IDX_LSB     = 2;
  localparam int unsigned STAT_W      = 16;
  localparam int STAT_MAX = (1 << STAT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [PC_W-1:0]   Id_PC;
  logic              Pred_Taken;
  logic              Ex_Valid;
  logic              Ex_Branch;
  logic [1:0]        Ex_Cond;
  logic              Ex_Is_Zero;
  logic              Ex_Is_Neg;
  logic [PC_W-1:0]   Ex_PC;
  logic              Ex_Pred_Taken;
  logic [PC_W-1:0]   Ex_Target;
  logic [PC_W-1:0]   Ex_PC_Plus4;
  logic              PCSrc;
  logic              Mispredict;
  logic [PC_W-1:0]   Redirect_PC;
  logic [STAT_W-1:0] Branch_Count;
  logic [STAT_W-1:0] Miss_Count;

  always #5 clk = ~clk;

  branch_predict_unit #(
    .PC_W        (PC_W),
    .BHT_ENTRIES (BHT_ENTRIES),
    .IDX_LSB     (IDX_LSB),
    .STAT_W      (STAT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .Id_PC         (Id_PC),
    .Pred_Taken    (Pred_Taken),
    .Ex_Valid      (Ex_Valid),
    .Ex_Branch     (Ex_Branch),
    .Ex_Cond       (Ex_Cond),
    .Ex_Is_Zero    (Ex_Is_Zero),
    .Ex_Is_Neg     (Ex_Is_Neg),
    .Ex_PC         (Ex_PC),
    .Ex_Pred_Taken (Ex_Pred_Taken),
    .Ex_Target     (Ex_Target),
    .Ex_PC_Plus4   (Ex_PC_Plus4),
    .PCSrc         (PCSrc),
    .Mispredict    (Mispredict),
    .Redirect_PC   (Redirect_PC),
    .Branch_Count  (Branch_Count),
    .Miss_Count    (Miss_Count)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: counter values as plain integers 0..3, statistics as integers.
  int tbl [BHT_ENTRIES];
  int m_branch;
  int m_miss;

  function automatic int idx_of(input logic [PC_W-1:0] pc);
    return int'((pc >> IDX_LSB) % BHT_ENTRIES);
  endfunction

  function automatic bit cond_taken(input logic [1:0] c, input logic z, input logic n);
    case (c)
      2'd0:    return z;
      2'd1:    return !z;
      2'd2:    return n;
      default: return !n;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge from the inputs present at that edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) tbl[i] = 1;
      m_branch = 0;
      m_miss   = 0;
    end else if (Ex_Valid && Ex_Branch) begin
      automatic bit t = cond_taken(Ex_Cond, Ex_Is_Zero, Ex_Is_Neg);
      automatic int k = idx_of(Ex_PC);
      if (t) tbl[k] = (tbl[k] == 3) ? 3 : tbl[k] + 1;
      else   tbl[k] = (tbl[k] == 0) ? 0 : tbl[k] - 1;
      if (m_branch < STAT_MAX) m_branch++;
      if ((t != Ex_Pred_Taken) && (m_miss < STAT_MAX)) m_miss++;
    end
  end

  // Compare process: all outputs against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      automatic bit res   = Ex_Valid && Ex_Branch;
      automatic bit e_src = res && cond_taken(Ex_Cond, Ex_Is_Zero, Ex_Is_Neg);
      automatic bit e_mis = res && (e_src != Ex_Pred_Taken);
      check("m_pcsrc", {31'd0, PCSrc}, {31'd0, e_src});
      check("m_mispredict", {31'd0, Mispredict}, {31'd0, e_mis});
      check("m_redirect", Redirect_PC, e_src ? Ex_Target : Ex_PC_Plus4);
      check("m_pred", {31'd0, Pred_Taken}, {31'd0, tbl[idx_of(Id_PC)] >= 2});
      check("m_branch_cnt", {16'd0, Branch_Count}, m_branch);
      check("m_miss_cnt", {16'd0, Miss_Count}, m_miss);
    end
  end

  task automatic idle();
    Ex_Valid      = 1'b0;
    Ex_Branch     = 1'b0;
    Ex_Cond       = 2'd0;
    Ex_Is_Zero    = 1'b0;
    Ex_Is_Neg     = 1'b0;
    Ex_PC         = '0;
    Ex_Pred_Taken = 1'b0;
    Ex_Target     = '0;
    Ex_PC_Plus4   = 32'h4;
  endtask

  task automatic drive_br(input logic [1:0] c, input logic z, input logic n,
                          input logic [PC_W-1:0] pc, input logic pred,
                          input logic [PC_W-1:0] tgt);
    Ex_Valid      = 1'b1;
    Ex_Branch     = 1'b1;
    Ex_Cond       = c;
    Ex_Is_Zero    = z;
    Ex_Is_Neg     = n;
    Ex_PC         = pc;
    Ex_Pred_Taken = pred;
    Ex_Target     = tgt;
    Ex_PC_Plus4   = pc + 32'd4;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit cond_exp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst   = 1'b1;
    Id_PC = 32'h40;
    idle();
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_pred", {31'd0, Pred_Taken}, 32'd0);
    check("rst_branch_cnt", {16'd0, Branch_Count}, 32'd0);
    check("rst_miss_cnt", {16'd0, Miss_Count}, 32'd0);

    // BEQ taken, predicted not-taken.
    step();
    drive_br(2'd0, 1'b1, 1'b0, 32'h40, 1'b0, 32'h80);
    @(negedge clk);
    check("beq_pcsrc", {31'd0, PCSrc}, 32'd1);
    check("beq_mispredict", {31'd0, Mispredict}, 32'd1);
    check("beq_redirect", Redirect_PC, 32'h80);
    step();
    idle();
    @(negedge clk);
    check("beq_pred_after", {31'd0, Pred_Taken}, 32'd1);
    check("beq_miss_cnt", {16'd0, Miss_Count}, 32'd1);

    // Saturate at strong-taken, then one not-taken leaves it predicting taken.
    step();
    repeat (4) begin
      drive_br(2'd0, 1'b1, 1'b0, 32'h40, 1'b1, 32'h80);
      step();
    end
    drive_br(2'd0, 1'b0, 1'b0, 32'h40, 1'b1, 32'h80);
    step();
    idle();
    @(negedge clk);
    check("sat_pred", {31'd0, Pred_Taken}, 32'd1);
    check("sat_branch_cnt", {16'd0, Branch_Count}, 32'd6);
    check("sat_miss_cnt", {16'd0, Miss_Count}, 32'd2);

    // Condition codes with Is_Zero=0, Is_Neg=1.
    step();
    for (int c = 0; c < 4; c++) begin
      drive_br(2'(c), 1'b0, 1'b1, 32'h100, 1'b0, 32'h200);
      @(negedge clk);
      check($sformatf("cond%0d_pcsrc", c), {31'd0, PCSrc}, {31'd0, cond_exp[c]});
      step();
    end
    drive_br(2'd1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h200);
    Ex_Valid = 1'b0;
    @(negedge clk);
    check("bubble_pcsrc", {31'd0, PCSrc}, 32'd0);
    check("bubble_mispredict", {31'd0, Mispredict}, 32'd0);
    step();
    idle();
    @(negedge clk);
    check("bubble_branch_cnt", {16'd0, Branch_Count}, 32'd10);
    check("bubble_miss_cnt", {16'd0, Miss_Count}, 32'd4);

    // Drop 0x40 to weak-NT, then train taken while reading it in the same cycle.
    step();
    drive_br(2'd0, 1'b0, 1'b0, 32'h40, 1'b1, 32'h80);
    step();
    Id_PC = 32'h40;
    drive_br(2'd0, 1'b1, 1'b0, 32'h40, 1'b0, 32'h80);
    @(negedge clk);
    check("same_cycle_old", {31'd0, Pred_Taken}, 32'd0);
    step();
    idle();
    Id_PC = 32'h80;
    @(negedge clk);
    check("alias_read", {31'd0, Pred_Taken}, 32'd1);
    check("alias_miss_cnt", {16'd0, Miss_Count}, 32'd6);

    // Randomized traffic with occasional resets.
    step();
    repeat (3000) begin
      rst = ($urandom_range(0, 99) == 0);
      Id_PC = $urandom & 32'h0000_00FC;
      Ex_Valid = $urandom_range(0, 3) != 0;
      Ex_Branch = $urandom_range(0, 3) != 0;
      Ex_Cond = 2'($urandom_range(0, 3));
      Ex_Is_Zero = 1'($urandom);
      Ex_Is_Neg = 1'($urandom);
      Ex_PC = $urandom & 32'h0000_00FC;
      Ex_Pred_Taken = 1'($urandom);
      Ex_Target = $urandom;
      Ex_PC_Plus4 = $urandom;
      step();
    end
    rst = 1'b0;
    idle();
    step();

    // Reset wins over a simultaneous mispredicting resolve.
    Id_PC = 32'h40;
    rst = 1'b1;
    drive_br(2'd0, 1'b1, 1'b0, 32'h40, 1'b0, 32'h80);
    @(negedge clk);
    check("rst_comb_mispredict", {31'd0, Mispredict}, 32'd1);
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("rst_win_pred", {31'd0, Pred_Taken}, 32'd0);
    check("rst_win_branch_cnt", {16'd0, Branch_Count}, 32'd0);
    check("rst_win_miss_cnt", {16'd0, Miss_Count}, 32'd0);
    for (int i = 0; i < BHT_ENTRIES; i++) begin
      Id_PC = 32'(i) << IDX_LSB;
      #0.1;
      check($sformatf("rst_entry%0d", i), {31'd0, Pred_Taken}, 32'd0);
    end
    Id_PC = 32'h40;

    // Statistics saturation.
    step();
    repeat ((1 << STAT_W) + 3) begin
      drive_br(2'd0, 1'b1, 1'b0, 32'h40, 1'b0, 32'h80);
      step();
    end
    idle();
    @(negedge clk);
    check("sat_miss_max", {16'd0, Miss_Count}, 32'h0000_FFFF);
    check("sat_branch_max", {16'd0, Branch_Count}, 32'h0000_FFFF);

    step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
